prbs11_g4_receive: RTL and testbench



---
 rtl/prbs11_g4_pkg.sv | 57 +++++
 rtl/prbs11_g4_ref_gen.sv | 63 ++++++
 rtl/prbs11_g4_receive.sv | 201 ++++++++++++++++++++
 tb/tb_prbs11_g4_receive.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs11_g4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs11_g4_pkg
//  Description : Shared constants, state encoding and LFSR helpers for the
//                Gen4 PRBS11 lane sender/receiver pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package prbs11_g4_pkg;

    // Lane seeds; sender and receiver on one lane must use the same seed
    localparam logic [10:0] SEED_LANE0 = 11'h7FF;
    localparam logic [10:0] SEED_LANE1 = 11'h770;

    // Feedback taps of x^11 + x^9 + 1 in the left-shifting form
    localparam int TAP_HI = 10;
    localparam int TAP_LO = 8;

    localparam int ROUND_LEN = 2048;
    localparam int OS_LEN    = 448;
    localparam int START_LEN = 12;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_e;

    // One LFSR step: shift left, feedback into bit 0
    function automatic logic [10:0] lfsr_step(input logic [10:0] s);
        return {s[9:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

    // Advance n steps; intended for elaboration-time constants only
    function automatic logic [10:0] lfsr_adv(input logic [10:0] state, input int n);
        logic [10:0] s;
        s = state;
        for (int i = 0; i < n; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    // R[0..11] of a round, R[0] in bit 11 (oldest bit of the search window)
    function automatic logic [11:0] start_pattern(input logic [10:0] seed);
        logic [11:0] p;
        logic [10:0] s;
        p     = '0;
        p[11] = seed[TAP_HI];
        for (int j = 1; j < START_LEN; j++) begin
            s          = lfsr_adv(seed, j - 1);
            p[11 - j]  = s[TAP_HI];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs11_g4_ref_gen.sv
`default_nettype none
// ============================================================================
//  Module      : prbs11_g4_ref_gen
//  Description : PRBS11 round replica: LFSR plus 11-bit round index. The LFSR
//                holds across the idx 0 -> 1 step (the hold bit) and advances
//                on every other step, so expected_o equals R[idx_o].
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs11_g4_ref_gen
    import prbs11_g4_pkg::*;
#(
    parameter logic [10:0] SEED = SEED_LANE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic        advance_i,
    output logic        expected_o,
    output logic [10:0] idx_o
);

    // Replica state after the 12-bit start pattern has been consumed
    localparam logic [10:0] LOAD_STATE = lfsr_adv(SEED, START_LEN - 1);
    localparam logic [10:0] LOAD_IDX   = 11'(START_LEN);

    logic [10:0] state_q, state_d;
    logic [10:0] idx_q, idx_d;

    // Next replica position: clear beats load beats advance
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clear_i) begin
            state_d = SEED;
            idx_d   = '0;
        end else if (load_i) begin
            state_d = LOAD_STATE;
            idx_d   = LOAD_IDX;
        end else if (advance_i) begin
            idx_d = idx_q + 11'd1;
            if (idx_q != 11'd0) begin
                state_d = lfsr_step(state_q);
            end
        end
    end

    // Replica registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign expected_o = state_q[TAP_HI];
    assign idx_o      = idx_q;

endmodule
`default_nettype wire

// File: rtl/prbs11_g4_receive.sv
`default_nettype none
// ============================================================================
//  Module      : prbs11_g4_receive
//  Description : Gen4 PRBS11 lane receiver. Searches for the round start
//                pattern, confirms alignment, then checks every bit against a
//                local replica and reports ordered-set boundaries, bit errors
//                and lock state.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs11_g4_receive
    import prbs11_g4_pkg::*;
#(
    parameter int lane0_lane1  = 1,
    parameter int CONFIRM_BITS = 64,
    parameter int LOSS_THRESH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        data_in,
    input  logic        clr_err,
    output logic        locked,
    output logic        os_received,
    output logic        round_start,
    output logic        bit_error,
    output logic [15:0] err_count
);

    // 1 selects the lane-0 seed, 0 the lane-1 seed
    localparam logic [10:0] SEED         = (lane0_lane1 != 0) ? SEED_LANE0 : SEED_LANE1;
    localparam logic [11:0] START_PAT    = start_pattern(SEED);
    localparam logic [7:0]  CONFIRM_LAST = 8'(CONFIRM_BITS - 1);
    localparam logic [3:0]  LOSS_LIM     = 4'(LOSS_THRESH);
    localparam logic [10:0] IDX_LAST     = 11'(ROUND_LEN - 1);
    localparam logic [8:0]  OS_LAST      = 9'(OS_LEN - 1);
    localparam logic [8:0]  OS_LOAD      = 9'(START_LEN);

    rx_state_e   state_q, state_d;
    logic [10:0] win_q, win_d;        // previous 11 bits; with data_in forms the 12-bit window
    logic [7:0]  conf_q, conf_d;
    logic [3:0]  rerr_q, rerr_d;
    logic [8:0]  os_q, os_d;
    logic        locked_q, locked_d;
    logic        osrx_q, osrx_d;
    logic        rs_q, rs_d;
    logic        be_q, be_d;
    logic [15:0] errc_q, errc_d;

    logic        w_clear, w_load, w_adv;
    logic        w_ref_bit;
    logic [10:0] w_idx;
    logic [11:0] w_win;
    logic        w_mismatch;
    logic [3:0]  w_rerr_base;
    logic [3:0]  w_rerr_inc;
    logic [8:0]  w_os_next;

    prbs11_g4_ref_gen #(
        .SEED(SEED)
    ) u_ref (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (w_clear),
        .load_i     (w_load),
        .advance_i  (w_adv),
        .expected_o (w_ref_bit),
        .idx_o      (w_idx)
    );

    assign w_win       = {win_q, data_in};
    assign w_mismatch  = data_in ^ w_ref_bit;
    // Per-round error count restarts on the bit with idx 0
    assign w_rerr_base = (w_idx == 11'd0) ? 4'd0 : rerr_q;
    assign w_rerr_inc  = w_rerr_base + 4'd1;
    // Ordered-set position follows idx: wraps at 447 and at the round end
    assign w_os_next   = (w_idx == IDX_LAST || os_q == OS_LAST) ? 9'd0 : os_q + 9'd1;

    // Receiver state machine, replica control and registered output terms
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        conf_d   = conf_q;
        rerr_d   = rerr_q;
        os_d     = os_q;
        errc_d   = errc_q;
        osrx_d   = 1'b0;
        rs_d     = 1'b0;
        be_d     = 1'b0;
        w_clear  = 1'b0;
        w_load   = 1'b0;
        w_adv    = 1'b0;

        if (!enable) begin
            state_d = ST_SEARCH;
            win_d   = '0;
            conf_d  = '0;
            rerr_d  = '0;
            os_d    = '0;
            w_clear = 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    win_d = w_win[10:0];
                    if (w_win == START_PAT) begin
                        state_d = ST_CONFIRM;
                        win_d   = '0;
                        conf_d  = '0;
                        os_d    = OS_LOAD;
                        w_load  = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    w_adv  = 1'b1;
                    os_d   = w_os_next;
                    rs_d   = (w_idx == 11'd0);
                    osrx_d = (os_q == OS_LAST);
                    if (w_mismatch) begin
                        be_d    = 1'b1;
                        state_d = ST_SEARCH;
                        win_d   = '0;
                        conf_d  = '0;
                        w_clear = 1'b1;
                    end else if (conf_q == CONFIRM_LAST) begin
                        state_d = ST_LOCKED;
                        conf_d  = '0;
                        rerr_d  = '0;
                    end else begin
                        conf_d = conf_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    w_adv  = 1'b1;
                    os_d   = w_os_next;
                    rs_d   = (w_idx == 11'd0);
                    osrx_d = (os_q == OS_LAST);
                    rerr_d = w_rerr_base;
                    if (w_mismatch) begin
                        be_d   = 1'b1;
                        rerr_d = w_rerr_inc;
                        if (errc_q != 16'hFFFF) begin
                            errc_d = errc_q + 16'd1;
                        end
                        if (w_rerr_inc >= LOSS_LIM) begin
                            state_d = ST_SEARCH;
                            rerr_d  = '0;
                            win_d   = '0;
                            w_clear = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    win_d   = '0;
                    w_clear = 1'b1;
                end
            endcase
        end

        // A clear request overrides a same-cycle increment
        if (clr_err) begin
            errc_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            win_q    <= '0;
            conf_q   <= '0;
            rerr_q   <= '0;
            os_q     <= '0;
            locked_q <= 1'b0;
            osrx_q   <= 1'b0;
            rs_q     <= 1'b0;
            be_q     <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            conf_q   <= conf_d;
            rerr_q   <= rerr_d;
            os_q     <= os_d;
            locked_q <= locked_d;
            osrx_q   <= osrx_d;
            rs_q     <= rs_d;
            be_q     <= be_d;
            errc_q   <= errc_d;
        end
    end

    assign locked      = locked_q;
    assign os_received = osrx_q;
    assign round_start = rs_q;
    assign bit_error   = be_q;
    assign err_count   = errc_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs11_g4_receive.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs11_g4_receive
//  Description : Directed self-checking bench for prbs11_g4_receive. dut_a
//                uses seed 7FF, dut_b seed 770. Each stream bit is driven,
//                then outputs are read 1 ns after the sampling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs11_g4_receive;

    logic        clk = 1'b0;
    logic        reset, clr_err;
    logic        enable_a, data_a, enable_b, data_b;
    logic        locked_a, os_a, rs_a, be_a;
    logic        locked_b, os_b, rs_b, be_b;
    logic [15:0] errc_a, errc_b;

    int checks = 0;
    int errors = 0;

    bit ra [2048];
    bit rb [2048];
    int pos_a, cur_a, pos_b, cur_b;

    always #5 clk = ~clk;

    prbs11_g4_receive #(.lane0_lane1(1), .CONFIRM_BITS(64), .LOSS_THRESH(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .data_in(data_a), .clr_err(clr_err),
        .locked(locked_a), .os_received(os_a), .round_start(rs_a), .bit_error(be_a),
        .err_count(errc_a)
    );

    prbs11_g4_receive #(.lane0_lane1(0), .CONFIRM_BITS(64), .LOSS_THRESH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .data_in(data_b), .clr_err(clr_err),
        .locked(locked_b), .os_received(os_b), .round_start(rs_b), .bit_error(be_b),
        .err_count(errc_b)
    );

    function automatic logic [3:0] obs_a();
        return {locked_a, os_a, rs_a, be_a};
    endfunction

    function automatic logic [3:0] obs_b();
        return {locked_b, os_b, rs_b, be_b};
    endfunction

    function automatic bit is_os(input int c);
        return (c == 447) || (c == 895) || (c == 1343) || (c == 1791);
    endfunction

    task automatic build_refs();
        logic [10:0] s;
        s = 11'h7FF;
        ra[0] = s[10];
        for (int k = 1; k < 2048; k++) begin
            ra[k] = s[10];
            s = {s[9:0], s[10] ^ s[8]};
        end
        s = 11'h770;
        rb[0] = s[10];
        for (int k = 1; k < 2048; k++) begin
            rb[k] = s[10];
            s = {s[9:0], s[10] ^ s[8]};
        end
    endtask

    task automatic send_a(input bit flip);
        data_a = ra[pos_a] ^ flip;
        @(posedge clk);
        #1;
        cur_a = pos_a;
        pos_a = (pos_a + 1) % 2048;
    endtask

    task automatic send_b(input bit flip);
        data_b = rb[pos_b] ^ flip;
        @(posedge clk);
        #1;
        cur_b = pos_b;
        pos_b = (pos_b + 1) % 2048;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr_err = 1'b0;
        enable_a = 1'b0; enable_b = 1'b0; data_a = 1'b0; data_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs_a() !== 4'b0000) begin errors++; $display("FAIL reset_outs_a: got %b want 0000", obs_a()); end
        checks++; if (errc_a !== 16'd0) begin errors++; $display("FAIL reset_errc_a: got %0d want 0", errc_a); end
        checks++; if (obs_b() !== 4'b0000) begin errors++; $display("FAIL reset_outs_b: got %b want 0000", obs_b()); end
        checks++; if (errc_b !== 16'd0) begin errors++; $display("FAIL reset_errc_b: got %0d want 0", errc_b); end
        reset = 1'b0;
    endtask

    // Bits 0..11 match the start pattern, bits 12..75 confirm; locked is
    // visible after the edge that samples bit 75 (i.e. while bit 76 is driven).
    task automatic test_lane0_loopback();
        int bad = 0, first_bad = -1, lock_n = -1, n_os = 0, n_rs = 0, n_be = 0;
        logic [3:0] exp, got, fg = '0, fe = '0;
        pos_a = 0;
        enable_a = 1'b1;
        for (int n = 0; n < 10 * 2048; n++) begin
            send_a(1'b0);
            got = obs_a();
            exp = {n >= 75, (n >= 12) && is_os(cur_a), (n >= 12) && (cur_a == 0), 1'b0};
            if (got !== exp || errc_a !== 16'd0) begin
                if (first_bad < 0) begin first_bad = n; fg = got; fe = exp; end
                bad++;
            end
            if (locked_a === 1'b1 && lock_n < 0) lock_n = n;
            if (os_a === 1'b1) n_os++;
            if (rs_a === 1'b1) n_rs++;
            if (be_a === 1'b1) n_be++;
        end
        checks++; if (lock_n !== 75) begin errors++; $display("FAIL lane0_lock_bit: got %0d want 75", lock_n); end
        checks++; if (n_os !== 40) begin errors++; $display("FAIL lane0_os_count: got %0d want 40", n_os); end
        checks++; if (n_rs !== 9) begin errors++; $display("FAIL lane0_rs_count: got %0d want 9", n_rs); end
        checks++; if (n_be !== 0) begin errors++; $display("FAIL lane0_bit_errors: got %0d want 0", n_be); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lane0_stream: %0d bad cycles, first bit %0d got %b want %b", bad, first_bad, fg, fe); end
    endtask

    task automatic test_single_error();
        int bad = 0, first_bad = -1, n_be = 0;
        logic [3:0] exp, got, fg = '0, fe = '0;
        for (int k = 0; k < 2048; k++) begin
            send_a(pos_a == 1000);
            got = obs_a();
            exp = {1'b1, is_os(cur_a), cur_a == 0, cur_a == 1000};
            if (got !== exp) begin
                if (first_bad < 0) begin first_bad = cur_a; fg = got; fe = exp; end
                bad++;
            end
            if (be_a === 1'b1) n_be++;
        end
        checks++; if (n_be !== 1) begin errors++; $display("FAIL single_err_pulses: got %0d want 1", n_be); end
        checks++; if (errc_a !== 16'd1) begin errors++; $display("FAIL single_err_count: got %0d want 1", errc_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL single_err_locked: got %b want 1", locked_a); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_err_stream: %0d bad cycles, first idx %0d got %b want %b", bad, first_bad, fg, fe); end
    endtask

    task automatic test_loss_of_lock();
        int bad = 0, first_bad = -1;
        bit wrapped, flip;
        logic lock_at_400 = 1'b1;
        logic [3:0] exp, got, fg = '0, fe = '0;
        for (int k = 0; k < 2048 + 81; k++) begin
            wrapped = (k >= 2048);
            flip = !wrapped && (pos_a == 100 || pos_a == 200 || pos_a == 300 || pos_a == 400);
            send_a(flip);
            got = obs_a();
            if (!wrapped)
                exp = {cur_a < 400, (cur_a <= 400) && is_os(cur_a), cur_a == 0, flip};
            else
                exp = {cur_a >= 75, (cur_a >= 12) && is_os(cur_a), 1'b0, 1'b0};
            if (!wrapped && cur_a == 400) lock_at_400 = locked_a;
            if (got !== exp) begin
                if (first_bad < 0) begin first_bad = k; fg = got; fe = exp; end
                bad++;
            end
        end
        checks++; if (lock_at_400 !== 1'b0) begin errors++; $display("FAIL loss_after_4th: got %b want 0", lock_at_400); end
        checks++; if (errc_a !== 16'd5) begin errors++; $display("FAIL loss_errc: got %0d want 5", errc_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL loss_relock: got %b want 1", locked_a); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL loss_stream: %0d bad cycles, first step %0d got %b want %b", bad, first_bad, fg, fe); end
    endtask

    task automatic test_lane1_midround();
        int bad = 0, first_bad = -1, early = 0;
        bit wrapped = 1'b0;
        logic [3:0] exp, got, fg = '0, fe = '0;
        enable_a = 1'b0;
        pos_b = 500;
        enable_b = 1'b1;
        for (int k = 0; k < (2048 - 500) + 81; k++) begin
            send_b(1'b0);
            if (cur_b == 0) wrapped = 1'b1;
            got = obs_b();
            exp = {wrapped && cur_b >= 75, wrapped && cur_b >= 12 && is_os(cur_b), 1'b0, 1'b0};
            if (!wrapped && locked_b === 1'b1) early++;
            if (got !== exp || errc_b !== 16'd0) begin
                if (first_bad < 0) begin first_bad = k; fg = got; fe = exp; end
                bad++;
            end
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL lane1_early_lock: got %0d cycles want 0", early); end
        checks++; if (locked_b !== 1'b1) begin errors++; $display("FAIL lane1_locked: got %b want 1", locked_b); end
        checks++; if (errc_b !== 16'd0) begin errors++; $display("FAIL lane1_errc: got %0d want 0", errc_b); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lane1_stream: %0d bad cycles, first step %0d got %b want %b", bad, first_bad, fg, fe); end
        enable_b = 1'b0;
    endtask

    task automatic test_confirm_error();
        int bad = 0, first_bad = -1, n_be = 0, lock_r1 = 0;
        bit wrapped;
        logic [3:0] exp, got, fg = '0, fe = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (obs_a() !== 4'b0000) begin errors++; $display("FAIL cfm_reset_outs: got %b want 0000", obs_a()); end
        checks++; if (errc_a !== 16'd0) begin errors++; $display("FAIL cfm_reset_errc: got %0d want 0", errc_a); end
        reset = 1'b0;
        pos_a = 0;
        enable_a = 1'b1;
        for (int k = 0; k < 2048 + 81; k++) begin
            wrapped = (k >= 2048);
            send_a(!wrapped && pos_a == 30);
            got = obs_a();
            if (!wrapped)
                exp = {1'b0, 1'b0, 1'b0, cur_a == 30};
            else
                exp = {cur_a >= 75, (cur_a >= 12) && is_os(cur_a), 1'b0, 1'b0};
            if (!wrapped && locked_a === 1'b1) lock_r1++;
            if (be_a === 1'b1) n_be++;
            if (got !== exp) begin
                if (first_bad < 0) begin first_bad = k; fg = got; fe = exp; end
                bad++;
            end
        end
        checks++; if (lock_r1 !== 0) begin errors++; $display("FAIL cfm_no_lock: got %0d cycles want 0", lock_r1); end
        checks++; if (n_be !== 1) begin errors++; $display("FAIL cfm_pulses: got %0d want 1", n_be); end
        checks++; if (errc_a !== 16'd0) begin errors++; $display("FAIL cfm_errc: got %0d want 0", errc_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL cfm_relock: got %b want 1", locked_a); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL cfm_stream: %0d bad cycles, first step %0d got %b want %b", bad, first_bad, fg, fe); end
    endtask

    task automatic test_enable_clear_reset();
        int bad = 0, first_bad = -1, guard = 0;
        bit wrapped = 1'b0, flip;
        logic [3:0] exp, got, fg = '0, fe = '0;
        // Three errors in the locked round (below the loss threshold)
        while (pos_a <= 800) begin
            flip = (pos_a == 500 || pos_a == 600 || pos_a == 700);
            send_a(flip);
            got = obs_a();
            exp = {1'b1, is_os(cur_a), 1'b0, flip};
            if (got !== exp) begin
                if (first_bad < 0) begin first_bad = cur_a; fg = got; fe = exp; end
                bad++;
            end
        end
        checks++; if (errc_a !== 16'd3) begin errors++; $display("FAIL ecr_errc3: got %0d want 3", errc_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL ecr_locked3: got %b want 1", locked_a); end
        // One cycle of enable low
        enable_a = 1'b0;
        send_a(1'b0);
        checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL ecr_en_off_locked: got %b want 0", locked_a); end
        checks++; if (errc_a !== 16'd3) begin errors++; $display("FAIL ecr_en_off_errc: got %0d want 3", errc_a); end
        enable_a = 1'b1;
        // Re-search and re-lock on the next round, stop before idx 100
        while (!(wrapped && pos_a == 100) && guard < 5000) begin
            guard++;
            send_a(1'b0);
            if (cur_a == 0) wrapped = 1'b1;
            got = obs_a();
            exp = {wrapped && cur_a >= 75, wrapped && cur_a >= 12 && is_os(cur_a), 1'b0, 1'b0};
            if (got !== exp) begin
                if (first_bad < 0) begin first_bad = cur_a; fg = got; fe = exp; end
                bad++;
            end
        end
        checks++; if (guard >= 5000) begin errors++; $display("FAIL ecr_relock_bound: got %0d steps want <5000", guard); end
        // Clear together with an error
        clr_err = 1'b1;
        send_a(1'b1);
        clr_err = 1'b0;
        checks++; if (be_a !== 1'b1) begin errors++; $display("FAIL ecr_clr_be: got %b want 1", be_a); end
        checks++; if (errc_a !== 16'd0) begin errors++; $display("FAIL ecr_clr_errc: got %0d want 0", errc_a); end
        checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL ecr_clr_locked: got %b want 1", locked_a); end
        // Reset in the middle of a round
        while (pos_a != 300) send_a(1'b0);
        reset = 1'b1;
        send_a(1'b0);
        reset = 1'b0;
        checks++; if (obs_a() !== 4'b0000) begin errors++; $display("FAIL ecr_reset_outs: got %b want 0000", obs_a()); end
        checks++; if (errc_a !== 16'd0) begin errors++; $display("FAIL ecr_reset_errc: got %0d want 0", errc_a); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ecr_stream: %0d bad cycles, first idx %0d got %b want %b", bad, first_bad, fg, fe); end
    endtask

    initial begin
        build_refs();
        test_reset();
        test_lane0_loopback();
        test_single_error();
        test_loss_of_lock();
        test_lane1_midround();
        test_confirm_error();
        test_enable_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
